// File: rtl/riscv_uart_rx.sv
// UART 8N1 receiver with a show-ahead FIFO and sticky error flags; define RISCV_UART_RX_PARITY_EN for 8E1.
// Latency: a byte reaches the FIFO head one cycle after its stop-bit sample.
// Backpressure: none on the line; a byte arriving with the FIFO full is dropped and flags overrun.
module riscv_uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_riscv_uart_rx_clk,
    input  logic                          i_riscv_uart_rx_rst,
    input  logic                          i_riscv_uart_rx_serial,
    input  logic                          i_riscv_uart_rx_rden,
    input  logic                          i_riscv_uart_rx_clr_err,
    output logic [7:0]                    o_riscv_uart_rx_rdata,
    output logic                          o_riscv_uart_rx_empty,
    output logic                          o_riscv_uart_rx_full,
    output logic [$clog2(FIFO_DEPTH):0]   o_riscv_uart_rx_count,
    output logic                          o_riscv_uart_rx_frame_err,
    output logic                          o_riscv_uart_rx_overrun,
    output logic                          o_riscv_uart_rx_parity_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]    DEPTH_C   = CW'(FIFO_DEPTH);

`ifdef RISCV_UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

    state_t           state;
    logic             sync1, sync2, prev;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             frame_err, overrun;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;

    logic full, empty, pop, stop_tick, push_req, push, drop, frame_set;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign pop       = i_riscv_uart_rx_rden && !empty;
    assign stop_tick = (state == STOP) && (bit_cnt == BIT_LAST);
    assign frame_set = stop_tick && !sync2;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the byte.
    assign push      = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;

`ifdef RISCV_UART_RX_PARITY_EN
    logic par_bad, par_err, par_set;
    assign par_set  = (state == PARITY) && (bit_cnt == BIT_LAST) && ((^shift) ^ sync2);
    assign push_req = stop_tick && sync2 && !par_bad;

    always_ff @(posedge i_riscv_uart_rx_clk) begin
        if (i_riscv_uart_rx_rst) begin
            par_err <= 1'b0;
            par_bad <= 1'b0;
        end else begin
            par_err <= (par_err && !i_riscv_uart_rx_clr_err) || par_set;
            if (state == IDLE)
                par_bad <= 1'b0;
            else if (par_set)
                par_bad <= 1'b1;
        end
    end
    assign o_riscv_uart_rx_parity_err = par_err;
`else
    assign push_req = stop_tick && sync2;
    assign o_riscv_uart_rx_parity_err = 1'b0;
`endif

    always_ff @(posedge i_riscv_uart_rx_clk) begin
        if (i_riscv_uart_rx_rst) begin
            state     <= IDLE;
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            prev      <= 1'b1;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            sync1     <= i_riscv_uart_rx_serial;
            sync2     <= sync1;
            prev      <= sync2;
            frame_err <= (frame_err && !i_riscv_uart_rx_clr_err) || frame_set;
            overrun   <= (overrun && !i_riscv_uart_rx_clr_err) || drop;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    bit_idx <= '0;
                    if (prev && !sync2)
                        state <= START;
                end
                START: begin
                    if (bit_cnt == HALF_LAST) begin
                        bit_cnt <= '0;
                        state   <= sync2 ? IDLE : DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        shift   <= {sync2, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
`ifdef RISCV_UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
`ifdef RISCV_UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        state   <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        // A low stop bit may be a break; wait for the line to recover.
                        state   <= sync2 ? IDLE : WAIT_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (sync2)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge i_riscv_uart_rx_clk) begin
        if (i_riscv_uart_rx_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= shift;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign o_riscv_uart_rx_rdata     = mem[rd_ptr];
    assign o_riscv_uart_rx_empty     = empty;
    assign o_riscv_uart_rx_full      = full;
    assign o_riscv_uart_rx_count     = count;
    assign o_riscv_uart_rx_frame_err = frame_err;
    assign o_riscv_uart_rx_overrun   = overrun;

endmodule

// File: tb/tb_riscv_uart_rx.sv
// Randomised self-checking bench for riscv_uart_rx against a queue-based receive model.
module tb_riscv_uart_rx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef RISCV_UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // Edges after the one that samples the falling pin: stop sample, then first non-empty.
    localparam int STOP_EDGE = 1 + CPB / 2 + (NB - 1) * CPB;

    logic       clk = 1'b0;
    logic       rst, serial, rden, clr_err;
    logic [7:0] rdata;
    logic       empty, full, frame_err, overrun, parity_err;
    logic [2:0] count;

    riscv_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_riscv_uart_rx_clk       (clk),
        .i_riscv_uart_rx_rst       (rst),
        .i_riscv_uart_rx_serial    (serial),
        .i_riscv_uart_rx_rden      (rden),
        .i_riscv_uart_rx_clr_err   (clr_err),
        .o_riscv_uart_rx_rdata     (rdata),
        .o_riscv_uart_rx_empty     (empty),
        .o_riscv_uart_rx_full      (full),
        .o_riscv_uart_rx_count     (count),
        .o_riscv_uart_rx_frame_err (frame_err),
        .o_riscv_uart_rx_overrun   (overrun),
        .o_riscv_uart_rx_parity_err(parity_err)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    bit         exp_fe, exp_ov, exp_pe;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(exp_q.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(exp_q.size() == 0));
        chk({tag, ".full"},  32'(full),  32'(exp_q.size() == DEPTH));
        chk({tag, ".ferr"},  32'(frame_err), 32'(exp_fe));
        chk({tag, ".ovr"},   32'(overrun),   32'(exp_ov));
        chk({tag, ".perr"},  32'(parity_err), 32'(exp_pe));
        if (exp_q.size() > 0)
            chk({tag, ".rdata"}, 32'(rdata), 32'(exp_q[0]));
    endtask

    // Serial frame LSB first: start, data, [even parity], stop.
    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
        logic [10:0] f;
        f = '1;
`ifdef RISCV_UART_RX_PARITY_EN
        f = {stop_ok, (^b) ^ !par_ok, b, 1'b0};
`else
        f[9:0] = {stop_ok, b, 1'b0};
`endif
        return f;
    endfunction

    task automatic drive_frame(input logic [10:0] fr, input int nb);
        @(posedge clk);
        #1;
        for (int i = 0; i < nb; i++) begin
            serial = fr[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit stop_ok, input bit par_ok);
        drive_frame(mk_frame(b, stop_ok, par_ok), NB);
        if (!par_ok)
            exp_pe = 1'b1;
        if (!stop_ok) begin
            exp_fe = 1'b1;
            repeat (8) @(posedge clk);
            #1 serial = 1'b1;
            repeat (4) @(posedge clk);
            #1;
        end else if (par_ok) begin
            if (exp_q.size() == DEPTH)
                exp_ov = 1'b1;
            else
                exp_q.push_back(b);
        end
    endtask

    task automatic pop(input string tag);
        if (exp_q.size() > 0)
            chk({tag, ".head"}, 32'(rdata), 32'(exp_q[0]));
        rden = 1'b1;
        @(posedge clk);
        #1 rden = 1'b0;
        if (exp_q.size() > 0)
            void'(exp_q.pop_front());
    endtask

    task automatic clear_errors();
        clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        exp_fe = 1'b0;
        exp_ov = 1'b0;
        exp_pe = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; serial = 1'b1; rden = 1'b0; clr_err = 1'b0;
        exp_fe = 0; exp_ov = 0; exp_pe = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset.rdata", 32'(rdata), 0);
        check_state("reset");

        // Single byte with exact latency measured from the edge that samples the low pin.
        n = 0;
        fork
            send(8'hA5, 1, 1);
            begin
                @(posedge clk);
                @(posedge clk);
                while (n < 400) begin
                    @(posedge clk);
                    n++;
                    #1;
                    if (!empty) break;
                end
            end
        join
        chk("single.latency", 32'(n), 32'(STOP_EDGE + 1));
        check_state("single");
        pop("single");
        check_state("single.pop");
        pop("empty_rden");
        check_state("empty_rden");

        // Glitch shorter than half a bit.
        @(posedge clk);
        #1 serial = 1'b0;
        repeat (5) @(posedge clk);
        #1 serial = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check_state("glitch");

        // Framing error with the line held low past the stop bit, then recovery.
        drive_frame(mk_frame(8'h3C, 0, 1), NB);
        exp_fe = 1'b1;
        repeat (40) @(posedge clk);
        #1 serial = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_state("frame");
        send(8'h11, 1, 1);
        check_state("frame.next");
        pop("frame.next");
        clear_errors();
        check_state("frame.clr");

        // Overrun: five bytes with no reads.
        for (int i = 1; i <= 5; i++) begin
            send(8'(i), 1, 1);
            check_state($sformatf("ovr.%0d", i));
        end
        for (int i = 0; i < 4; i++)
            pop("ovr.pop");
        check_state("ovr.drained");
        clear_errors();

        // Pop in the stop-sample cycle of a frame arriving at a full FIFO.
        for (int i = 1; i <= 4; i++)
            send(8'(i), 1, 1);
        fork
            drive_frame(mk_frame(8'h06, 1, 1), NB);
            begin
                @(posedge clk);
                @(posedge clk);
                repeat (STOP_EDGE) @(posedge clk);
                #1 rden = 1'b1;
                @(posedge clk);
                #1 rden = 1'b0;
            end
        join
        void'(exp_q.pop_front());
        exp_q.push_back(8'h06);
        check_state("simul");
        while (exp_q.size() > 0)
            pop("simul.pop");
        check_state("simul.drained");

        // Random traffic with interleaved reads, bad stops and error clears.
        for (int f = 0; f < 30; f++) begin
            int   npop;
            logic [7:0] b;
            bit   s_ok;
            npop = $urandom_range(0, 3);
            for (int p = 0; p < npop; p++)
                pop("rnd.pop");
            if ($urandom_range(0, 5) == 0)
                clear_errors();
            b    = 8'($urandom);
            s_ok = ($urandom_range(0, 7) != 0);
            send(b, s_ok, 1);
            check_state($sformatf("rnd.%0d", f));
        end
        while (exp_q.size() > 0)
            pop("rnd.drain");
        clear_errors();
        check_state("rnd.end");

        // Reset in the middle of a frame with a byte already queued.
        send(8'h5A, 1, 1);
        check_state("rst.pre");
        drive_frame(mk_frame(8'h77, 1, 1), 5);
        rst = 1'b1;
        serial = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        exp_fe = 0; exp_ov = 0; exp_pe = 0;
        chk("rst.rdata", 32'(rdata), 0);
        check_state("rst.mid");
        repeat (200) @(posedge clk);
        #1;
        check_state("rst.after");

`ifdef RISCV_UART_RX_PARITY_EN
        send(8'h07, 1, 0);
        check_state("parity.bad");
        clear_errors();
        send(8'h07, 1, 1);
        check_state("parity.good");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
